// File: rtl/rand_pkg.sv
// Shared types and helpers for the bounded random sampler.
package rand_pkg;

    localparam int REJ_CNT_W = 16;

    typedef enum logic {
        SAMPLE,
        HOLD
    } sampler_state_t;

    // Smallest k with 2**k >= span+1, clamped to 1..32.
    function automatic int range_bits(int span);
        int k;
        k = 32;
        for (int i = 32; i >= 1; i--) begin
            if ((longint'(1) << i) >= (longint'(span) + 64'sd1)) begin
                k = i;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/rand_health_mon.sv
// Repetition-count health test on the raw entropy word. A fault latches once
// REP_LIMIT identical consecutive words have been seen and stays set until reset.
module rand_health_mon #(
    parameter int REP_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rand_word,
    output logic        fault
);

    logic [31:0] prev_word;
    logic [7:0]  rep_cnt;

    // Track the run length of identical words and latch the sticky fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_word <= '0;
            rep_cnt   <= '0;
            fault     <= 1'b0;
        end else begin
            prev_word <= rand_word;
            if (rand_word != prev_word) begin
                rep_cnt <= '0;
            end else if (rep_cnt != 8'(REP_LIMIT - 1)) begin
                rep_cnt <= rep_cnt + 8'd1;
            end
            if (rep_cnt == 8'(REP_LIMIT - 1)) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Rejection sampler producing uniform values in [MIN, MAX] from a free-running
// 32-bit random word, presented on a valid/ready handshake.
// Optional health monitor enabled with macro RAND_HEALTH_EN; when undefined
// rng_fault is tied low.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int OUT_W     = 10,
    parameter int MIN       = 120,
    parameter int MAX       = 360,
    parameter int MAX_TRIES = 8,
    parameter int REP_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          rand_word,
    output logic [OUT_W-1:0]     out_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REJ_CNT_W-1:0] reject_cnt,
    output logic                 rng_fault
);

    localparam int SPAN = MAX - MIN;
    localparam int K    = range_bits(SPAN);

    // Parameter sanity, caught at elaboration.
    if (MAX <= MIN) begin : g_chk_range
        $error("rand_range_sampler: MAX must be greater than MIN");
    end
    if (longint'(MAX) >= (longint'(1) << OUT_W)) begin : g_chk_width
        $error("rand_range_sampler: MAX does not fit in OUT_W bits");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_chk_tries
        $error("rand_range_sampler: MAX_TRIES must be 1..255");
    end
    if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_chk_rep
        $error("rand_range_sampler: REP_LIMIT must be 2..255");
    end

    // Saturating increment for the reject counter.
    function automatic logic [REJ_CNT_W-1:0] sat_inc(input logic [REJ_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    sampler_state_t        state, state_next;
    logic [7:0]            tries, tries_next;
    logic [OUT_W-1:0]      value_next;
    logic                  valid_next;
    logic [REJ_CNT_W-1:0]  rej_next;

    logic [K-1:0]          cand;
    logic [31:0]           cand_ext;
    logic                  cand_ok;
    logic [OUT_W-1:0]      accept_value;
    logic [OUT_W-1:0]      fallback_value;
    logic                  unused_rand;

    // Only the low K bits feed the sampler; the rest are consumed here.
    assign unused_rand    = ^rand_word;
    assign cand           = rand_word[K-1:0];
    assign cand_ext       = 32'(cand);
    assign cand_ok        = (cand_ext <= 32'(SPAN));
    // Halving a K-bit candidate always lands inside the span, so the
    // fallback never leaves [MIN, MAX].
    assign accept_value   = OUT_W'(MIN) + OUT_W'(cand_ext);
    assign fallback_value = OUT_W'(MIN) + OUT_W'(cand_ext >> 1);

    // Next-state and output decode: accept, reject or fall back in SAMPLE,
    // wait for the handshake in HOLD.
    always_comb begin
        state_next = state;
        tries_next = tries;
        value_next = out_value;
        valid_next = out_valid;
        rej_next   = reject_cnt;
        case (state)
            SAMPLE: begin
                if (cand_ok) begin
                    value_next = accept_value;
                    valid_next = 1'b1;
                    tries_next = '0;
                    state_next = HOLD;
                end else if (tries < 8'(MAX_TRIES - 1)) begin
                    tries_next = tries + 8'd1;
                    rej_next   = sat_inc(reject_cnt);
                end else begin
                    value_next = fallback_value;
                    valid_next = 1'b1;
                    rej_next   = sat_inc(reject_cnt);
                    tries_next = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    valid_next = 1'b0;
                    state_next = SAMPLE;
                end
            end
            default: begin
                state_next = SAMPLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SAMPLE;
            tries      <= '0;
            out_value  <= '0;
            out_valid  <= 1'b0;
            reject_cnt <= '0;
        end else begin
            state      <= state_next;
            tries      <= tries_next;
            out_value  <= value_next;
            out_valid  <= valid_next;
            reject_cnt <= rej_next;
        end
    end

`ifdef RAND_HEALTH_EN
    rand_health_mon #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health (
        .clk       (clk),
        .rst_n     (rst_n),
        .rand_word (rand_word),
        .fault     (rng_fault)
    );
`else
    assign rng_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler (MIN=120, MAX=360, MAX_TRIES=4) plus a
// second instance whose span+1 is a power of two (MIN=10, MAX=73).
module tb_rand_range_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rand_word;
    logic        out_ready;
    logic [9:0]  out_value;
    logic        out_valid;
    logic [15:0] reject_cnt;
    logic        rng_fault;

    logic [9:0]  out_value2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] reject_cnt2;
    logic        rng_fault2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rand_range_sampler #(
        .OUT_W(10), .MIN(120), .MAX(360), .MAX_TRIES(4), .REP_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_word  (rand_word),
        .out_value  (out_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reject_cnt (reject_cnt),
        .rng_fault  (rng_fault)
    );

    rand_range_sampler #(
        .OUT_W(10), .MIN(10), .MAX(73), .MAX_TRIES(4), .REP_LIMIT(8)
    ) dut_pow2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_word  (rand_word),
        .out_value  (out_value2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .reject_cnt (reject_cnt2),
        .rng_fault  (rng_fault2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_value", 32'(out_value), 32'd0);
        check("rst_rej",   32'(reject_cnt), 32'd0);
        check("rst_fault", 32'(rng_fault), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rand_word  = 32'h0;
        out_ready  = 1'b0;
        out_ready2 = 1'b1;
        step();
        apply_reset();

        // Plain accept: cand 16 -> 136 one cycle later.
        rand_word = 32'h0000_0010;
        step();
        check("acc_valid", 32'(out_valid), 32'd1);
        check("acc_value", 32'(out_value), 32'd136);
        check("acc_rej",   32'(reject_cnt), 32'd0);

        // Consume, then the top of the span (cand 240 -> 360).
        out_ready = 1'b1;
        step();
        check("hs_valid_low", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        rand_word = 32'h0000_00F0;
        step();
        check("edge_valid", 32'(out_valid), 32'd1);
        check("edge_value", 32'(out_value), 32'd360);
        check("edge_rej",   32'(reject_cnt), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reject (245) then accept (0x10 -> 136).
        rand_word = 32'h0000_00F5;
        step();
        check("rej_valid", 32'(out_valid), 32'd0);
        check("rej_cnt1",  32'(reject_cnt), 32'd1);
        rand_word = 32'h1234_5610;
        step();
        check("rej_acc_valid", 32'(out_valid), 32'd1);
        check("rej_acc_value", 32'(out_value), 32'd136);
        check("rej_acc_cnt",   32'(reject_cnt), 32'd1);

        // Fallback: 0xFF rejected four times, value 120 + 127.
        apply_reset();
        rand_word = 32'h0000_00FF;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("fb_wait_valid", 32'(out_valid), 32'd0);
            check("fb_wait_rej",   32'(reject_cnt), 32'(i));
        end
        step();
        check("fb_valid", 32'(out_valid), 32'd1);
        check("fb_value", 32'(out_value), 32'd247);
        check("fb_rej",   32'(reject_cnt), 32'd4);

        // Backpressure: 136 held for 10 cycles while the source keeps changing.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rand_word = 32'h0000_0010;
        step();
        check("bp_valid0", 32'(out_valid), 32'd1);
        check("bp_value0", 32'(out_value), 32'd136);
        for (int i = 0; i < 10; i++) begin
            rand_word = $urandom;
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_value", 32'(out_value), 32'd136);
        end
        check("bp_rej", 32'(reject_cnt), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        rand_word = 32'h0000_0020;
        step();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_value", 32'(out_value), 32'd152);

        // Reset while holding a value.
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_value", 32'(out_value), 32'd0);
        check("mid_rst_rej",   32'(reject_cnt), 32'd0);
        rst_n     = 1'b1;
        rand_word = 32'h0000_0005;
        step();
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_value", 32'(out_value), 32'd125);

        // Health: eight identical words, then a different one.
        apply_reset();
        out_ready = 1'b1;
        rand_word = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        check("pow2_value", 32'(out_value2), 32'd57);
        rand_word = 32'h0000_1234;
        step();
`ifdef RAND_HEALTH_EN
        check("health_fault", 32'(rng_fault), 32'd1);
        rand_word = 32'h0000_5678;
        step();
        check("health_sticky", 32'(rng_fault), 32'd1);
`else
        check("health_off", 32'(rng_fault), 32'd0);
`endif
        check("pow2_rej", 32'(reject_cnt2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
